// File: rtl/ctrl_frame_decoder.sv
// Frame decoder: locks onto the 12/16/4 strobe spacing and captures three words per frame.
// Optional error counter output o_err_count is enabled by defining CTRL_FRAME_STATS_EN.
module ctrl_frame_decoder #(
  parameter int WIDTH   = 8,
  parameter int GAP0    = 12,
  parameter int GAP1    = 16,
  parameter int GAP2    = 4,
  parameter int TIMEOUT = 64
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_ctrl,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_slot0,
  output logic [WIDTH-1:0] o_slot1,
  output logic [WIDTH-1:0] o_slot2,
  output logic             o_frame_valid,
  output logic             o_locked,
  output logic             o_err
`ifdef CTRL_FRAME_STATS_EN
  ,
  output logic [7:0]       o_err_count
`endif
);

  // state  | meaning
  // SEARCH | not locked, waiting for a GAP0 strobe (after the first one seen)
  // EXP0   | locked, next strobe should be slot 0 (GAP0 after slot 2)
  // EXP1   | slot 0 captured, next strobe should be slot 1
  // EXP2   | slot 1 captured, next strobe should be slot 2
  localparam logic [1:0] S_SEARCH = 2'd0;
  localparam logic [1:0] S_EXP0   = 2'd1;
  localparam logic [1:0] S_EXP1   = 2'd2;
  localparam logic [1:0] S_EXP2   = 2'd3;

  localparam logic [6:0] L_GAP0   = 7'(GAP0);
  localparam logic [6:0] L_GAP1   = 7'(GAP1);
  localparam logic [6:0] L_GAP2   = 7'(GAP2);
  localparam logic [6:0] L_CNTMAX = 7'(TIMEOUT - 1);

  logic [1:0]       r_state;
  logic [6:0]       r_gap_cnt;
  logic             r_seen;
  logic [WIDTH-1:0] r_shadow0;
  logic [WIDTH-1:0] r_shadow1;

  logic [1:0] w_state_nxt;
  logic [6:0] w_gap;
  logic       w_cap0;
  logic       w_cap1;
  logic       w_frame;
  logic       w_err;

  // Gap counts the strobe cycle itself, hence the +1; TIMEOUT <= 127 keeps it in 7 bits.
  assign w_gap = r_gap_cnt + 7'd1;

  always_comb begin
    w_state_nxt = r_state;
    w_cap0      = 1'b0;
    w_cap1      = 1'b0;
    w_frame     = 1'b0;
    w_err       = 1'b0;
    if (i_ctrl) begin
      case (r_state)
        S_SEARCH: begin
          if (r_seen && (w_gap == L_GAP0)) begin
            w_cap0      = 1'b1;
            w_state_nxt = S_EXP1;
          end
        end
        S_EXP0: begin
          if (w_gap == L_GAP0) begin
            w_cap0      = 1'b1;
            w_state_nxt = S_EXP1;
          end else begin
            w_err       = 1'b1;
            w_state_nxt = S_SEARCH;
          end
        end
        S_EXP1: begin
          if (w_gap == L_GAP1) begin
            w_cap1      = 1'b1;
            w_state_nxt = S_EXP2;
          end else begin
            w_err       = 1'b1;
            w_state_nxt = S_SEARCH;
          end
        end
        S_EXP2: begin
          if (w_gap == L_GAP2) begin
            w_frame     = 1'b1;
            w_state_nxt = S_EXP0;
          end else begin
            w_err       = 1'b1;
            w_state_nxt = S_SEARCH;
          end
        end
        default: w_state_nxt = S_SEARCH;
      endcase
    end else if ((r_state != S_SEARCH) && (r_gap_cnt == L_CNTMAX)) begin
      // Timeout fires only while tracking; SEARCH sits quietly at saturation.
      w_err       = 1'b1;
      w_state_nxt = S_SEARCH;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state       <= S_SEARCH;
      r_gap_cnt     <= 7'd0;
      r_seen        <= 1'b0;
      r_shadow0     <= '0;
      r_shadow1     <= '0;
      o_slot0       <= '0;
      o_slot1       <= '0;
      o_slot2       <= '0;
      o_frame_valid <= 1'b0;
      o_locked      <= 1'b0;
      o_err         <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (i_ctrl) begin
        r_gap_cnt <= 7'd0;
        r_seen    <= 1'b1;
      end else if (r_gap_cnt != L_CNTMAX) begin
        r_gap_cnt <= r_gap_cnt + 7'd1;
      end
      if (w_cap0) r_shadow0 <= i_data;
      if (w_cap1) r_shadow1 <= i_data;
      if (w_frame) begin
        o_slot0  <= r_shadow0;
        o_slot1  <= r_shadow1;
        o_slot2  <= i_data;
        o_locked <= 1'b1;
      end else if (w_err) begin
        o_locked <= 1'b0;
      end
      o_frame_valid <= w_frame;
      o_err         <= w_err;
    end
  end

`ifdef CTRL_FRAME_STATS_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      o_err_count <= 8'd0;
    end else if (w_err && (o_err_count != 8'hFF)) begin
      o_err_count <= o_err_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ctrl_frame_decoder.sv
// Directed bench for ctrl_frame_decoder: strobe-gap vector table plus timeout/reset/stats sequences.
module tb_ctrl_frame_decoder;

  logic       clock = 1'b0;
  logic       reset;
  logic       i_ctrl;
  logic [7:0] i_data;
  logic [7:0] o_slot0, o_slot1, o_slot2;
  logic       o_frame_valid, o_locked, o_err;
`ifdef CTRL_FRAME_STATS_EN
  logic [7:0] o_err_count;
`endif

  ctrl_frame_decoder dut (
    .clock         (clock),
    .reset         (reset),
    .i_ctrl        (i_ctrl),
    .i_data        (i_data),
    .o_slot0       (o_slot0),
    .o_slot1       (o_slot1),
    .o_slot2       (o_slot2),
    .o_frame_valid (o_frame_valid),
    .o_locked      (o_locked),
    .o_err         (o_err)
`ifdef CTRL_FRAME_STATS_EN
    ,
    .o_err_count   (o_err_count)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    int         gap;
    logic [7:0] data;
    logic       v;
    logic       lk;
    logic       er;
    logic [7:0] s0, s1, s2;
  } vec_t;

  vec_t vt[49];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic exp_lk = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
    end
  endtask

  task automatic sv(input int i, input int g, input logic [7:0] d, input logic v,
                    input logic lk, input logic er, input logic [7:0] s0,
                    input logic [7:0] s1, input logic [7:0] s2);
    vt[i] = '{g, d, v, lk, er, s0, s1, s2};
  endtask

  // Idle gap-1 cycles (checking quiet outputs), then strobe so the measured gap equals vt[i].gap.
  task automatic apply_vec(input int i);
    for (int k = 1; k < vt[i].gap; k++) begin
      i_ctrl = 1'b0;
      @(posedge clock); #1;
      check($sformatf("v%0d_idle_valid", i), o_frame_valid, 1'b0);
      check($sformatf("v%0d_idle_err", i), o_err, 1'b0);
      check($sformatf("v%0d_idle_locked", i), o_locked, exp_lk);
    end
    i_ctrl = 1'b1;
    i_data = vt[i].data;
    @(posedge clock); #1;
    i_ctrl = 1'b0;
    check($sformatf("v%0d_valid", i), o_frame_valid, vt[i].v);
    check($sformatf("v%0d_locked", i), o_locked, vt[i].lk);
    check($sformatf("v%0d_err", i), o_err, vt[i].er);
    check($sformatf("v%0d_slot0", i), o_slot0, vt[i].s0);
    check($sformatf("v%0d_slot1", i), o_slot1, vt[i].s1);
    check($sformatf("v%0d_slot2", i), o_slot2, vt[i].s2);
    exp_lk = vt[i].lk;
  endtask

  task automatic apply_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) apply_vec(i);
  endtask

  task automatic strobe_after(input int gap, input logic [7:0] d);
    i_ctrl = 1'b0;
    for (int k = 1; k < gap; k++) @(posedge clock);
    #1;
    i_ctrl = 1'b1;
    i_data = d;
    @(posedge clock); #1;
    i_ctrl = 1'b0;
  endtask

  task automatic check_all_zero(input string nm);
    check({nm, "_slot0"}, o_slot0, 8'h00);
    check({nm, "_slot1"}, o_slot1, 8'h00);
    check({nm, "_slot2"}, o_slot2, 8'h00);
    check({nm, "_valid"}, o_frame_valid, 1'b0);
    check({nm, "_locked"}, o_locked, 1'b0);
    check({nm, "_err"}, o_err, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  k;
    bit  got;
    int  extra;

    // gap, data, valid, locked, err, slot0, slot1, slot2
    sv( 0,  5, 8'h11, 0, 0, 0, 8'h00, 8'h00, 8'h00);  // first strobe only arms
    sv( 1, 12, 8'h11, 0, 0, 0, 8'h00, 8'h00, 8'h00);
    sv( 2, 16, 8'h22, 0, 0, 0, 8'h00, 8'h00, 8'h00);
    sv( 3,  4, 8'h33, 1, 1, 0, 8'h11, 8'h22, 8'h33);
    sv( 4, 12, 8'h44, 0, 1, 0, 8'h11, 8'h22, 8'h33);
    sv( 5, 16, 8'h55, 0, 1, 0, 8'h11, 8'h22, 8'h33);
    sv( 6,  4, 8'h66, 1, 1, 0, 8'h44, 8'h55, 8'h66);
    sv( 7, 12, 8'h11, 0, 1, 0, 8'h44, 8'h55, 8'h66);
    sv( 8, 15, 8'h22, 0, 0, 1, 8'h44, 8'h55, 8'h66);  // slot-1 at 19
    sv( 9,  5, 8'h33, 0, 0, 0, 8'h44, 8'h55, 8'h66);
    sv(10, 12, 8'h11, 0, 0, 0, 8'h44, 8'h55, 8'h66);
    sv(11, 16, 8'h22, 0, 0, 0, 8'h44, 8'h55, 8'h66);
    sv(12,  4, 8'h33, 1, 1, 0, 8'h11, 8'h22, 8'h33);
    sv(13, 12, 8'h77, 0, 1, 0, 8'h11, 8'h22, 8'h33);
    sv(14,  6, 8'h99, 0, 0, 1, 8'h11, 8'h22, 8'h33);  // spurious at 10
    sv(15, 10, 8'h88, 0, 0, 0, 8'h11, 8'h22, 8'h33);
    sv(16,  4, 8'h89, 0, 0, 0, 8'h11, 8'h22, 8'h33);
    sv(17, 12, 8'hA1, 0, 0, 0, 8'h11, 8'h22, 8'h33);
    sv(18, 16, 8'hA2, 0, 0, 0, 8'h11, 8'h22, 8'h33);
    sv(19,  4, 8'hA3, 1, 1, 0, 8'hA1, 8'hA2, 8'hA3);
    sv(20, 12, 8'hB1, 0, 1, 0, 8'hA1, 8'hA2, 8'hA3);
    sv(21,  1, 8'hB2, 0, 0, 1, 8'hA1, 8'hA2, 8'hA3);  // back-to-back
    sv(22,  1, 8'hB3, 0, 0, 0, 8'hA1, 8'hA2, 8'hA3);
    sv(23, 12, 8'hC1, 0, 0, 0, 8'hA1, 8'hA2, 8'hA3);
    sv(24, 12, 8'hC2, 0, 0, 1, 8'hA1, 8'hA2, 8'hA3);  // erroring strobe must not re-arm
    sv(25, 16, 8'hC3, 0, 0, 0, 8'hA1, 8'hA2, 8'hA3);
    sv(26,  4, 8'hC4, 0, 0, 0, 8'hA1, 8'hA2, 8'hA3);
    sv(27, 12, 8'hD1, 0, 0, 0, 8'hA1, 8'hA2, 8'hA3);
    sv(28, 16, 8'hD2, 0, 0, 0, 8'hA1, 8'hA2, 8'hA3);
    sv(29,  4, 8'hD3, 1, 1, 0, 8'hD1, 8'hD2, 8'hD3);
    sv(30, 12, 8'hE1, 0, 1, 0, 8'hD1, 8'hD2, 8'hD3);
    sv(31, 64, 8'hE2, 0, 0, 1, 8'hD1, 8'hD2, 8'hD3);  // strobe coincides with timeout
    sv(32, 64, 8'hE3, 0, 0, 0, 8'hD1, 8'hD2, 8'hD3);
    sv(33, 12, 8'hF1, 0, 0, 0, 8'hD1, 8'hD2, 8'hD3);
    sv(34, 16, 8'hF2, 0, 0, 0, 8'hD1, 8'hD2, 8'hD3);
    sv(35,  4, 8'hF3, 1, 1, 0, 8'hF1, 8'hF2, 8'hF3);
    sv(36, 12, 8'hF4, 0, 1, 0, 8'hF1, 8'hF2, 8'hF3);
    sv(37, 16, 8'hF5, 0, 1, 0, 8'hF1, 8'hF2, 8'hF3);
    sv(38, 30, 8'h60, 0, 0, 0, 8'hF1, 8'hF2, 8'hF3);
    sv(39, 12, 8'h61, 0, 0, 0, 8'hF1, 8'hF2, 8'hF3);
    sv(40, 16, 8'h62, 0, 0, 0, 8'hF1, 8'hF2, 8'hF3);
    sv(41,  4, 8'h63, 1, 1, 0, 8'h61, 8'h62, 8'h63);
    sv(42, 12, 8'h71, 0, 1, 0, 8'h61, 8'h62, 8'h63);
    sv(43, 12, 8'h5A, 0, 0, 0, 8'h00, 8'h00, 8'h00);  // first after reset: never matched
    sv(44, 16, 8'h5B, 0, 0, 0, 8'h00, 8'h00, 8'h00);
    sv(45,  4, 8'h5C, 0, 0, 0, 8'h00, 8'h00, 8'h00);
    sv(46, 12, 8'hC7, 0, 0, 0, 8'h00, 8'h00, 8'h00);
    sv(47, 16, 8'hC8, 0, 0, 0, 8'h00, 8'h00, 8'h00);
    sv(48,  4, 8'hC9, 1, 1, 0, 8'hC7, 8'hC8, 8'hC9);

    reset  = 1'b1;
    i_ctrl = 1'b0;
    i_data = 8'h00;
    repeat (2) @(posedge clock);
    #1;
    check_all_zero("reset");
    reset = 1'b0;

    apply_range(0, 37);

    // Timeout while waiting for slot 2
    k = 0;
    got = 1'b0;
    while (!got && k < 200) begin
      @(posedge clock); #1;
      k++;
      if (o_err) got = 1'b1;
      else check("to_hold_locked", o_locked, 1'b1);
    end
    check("to_seen", got, 1'b1);
    check("to_cycles", k, 64);
    check("to_locked", o_locked, 1'b0);
    exp_lk = 1'b0;
    extra = 0;
    for (int c = 0; c < 150; c++) begin
      @(posedge clock); #1;
      if (o_err) extra++;
    end
    check("to_no_repeat", extra, 0);
    check("to_slot0", o_slot0, 8'hF1);
    check("to_slot1", o_slot1, 8'hF2);
    check("to_slot2", o_slot2, 8'hF3);

    apply_range(38, 42);

`ifdef CTRL_FRAME_STATS_EN
    check("stats_main_count", o_err_count, 8'd6);
`endif

    // Asynchronous reset between slot-0 and slot-1
    repeat (5) @(posedge clock);
    #3;
    reset = 1'b1;
    #1;
    check_all_zero("midrst");
`ifdef CTRL_FRAME_STATS_EN
    check("midrst_count", o_err_count, 8'd0);
`endif
    @(posedge clock); #1;
    reset  = 1'b0;
    exp_lk = 1'b0;
    apply_range(43, 48);

`ifdef CTRL_FRAME_STATS_EN
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    check("stats_reset", o_err_count, 8'd0);
    strobe_after(3, 8'h00);
    for (int i = 0; i < 300; i++) begin
      strobe_after(12, 8'h01);
      strobe_after(1, 8'h02);
      if (i == 0) check("stats_err_pulse", o_err, 1'b1);
      if (i == 99) check("stats_count_100", o_err_count, 8'd100);
    end
    check("stats_saturated", o_err_count, 8'd255);
    #3;
    reset = 1'b1;
    #1;
    check("stats_reset_clear", o_err_count, 8'd0);
    @(posedge clock); #1;
    reset = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ctrl_frame_decoder.md
# ctrl_frame_decoder

Downstream consumer of the frame-timing control-pulse generator. The generator emits single-cycle strobes at cycles 4, 20 and 24 of a free-running 32-cycle frame. This block measures the spacing between strobes to lock onto that frame. It captures one data word per strobe and presents a complete three-slot frame with a one-cycle valid pulse; timing loss is reported as an error.

## Interface
Parameters:
- WIDTH, 8, width of each captured data word
- GAP0, 12, expected cycles from previous strobe to slot-0 strobe (24 → 4 across the wrap)
- GAP1, 16, expected cycles from slot-0 to slot-1 strobe (4 → 20)
- GAP2, 4, expected cycles from slot-1 to slot-2 strobe (20 → 24)
- TIMEOUT, 64, measured-gap saturation value; must exceed GAP0/1/2 and be ≤ 127

Ports:
- clock  in  1  single clock, all logic on posedge
- reset  in  1  asynchronous, active-high reset
- i_ctrl  in  1  single-cycle strobe from the pulse generator
- i_data  in  WIDTH  data word sampled on strobe cycles
- o_slot0, o_slot1, o_slot2  out  WIDTH each  last complete frame's words
- o_frame_valid  out  1  one-cycle pulse: new frame on o_slot*
- o_locked  out  1  high after first complete frame, until an error
- o_err  out  1  one-cycle pulse on gap mismatch or timeout

## Operation
- Gap counter gap_cnt, 7 bits: cleared to 0 on any cycle with i_ctrl=1.
- On every other cycle, gap_cnt increments and saturates at TIMEOUT-1.
- Measured gap on a strobe cycle = gap_cnt+1. Example: strobes at 4 and 20 give a measured gap of 16.
- Flag seen: set on the first strobe after reset. The first strobe after reset only starts the gap measurement and is never matched.
- States: SEARCH, EXP0, EXP1, EXP2.
- SEARCH: strobe with seen=1 and gap==GAP0 → capture i_data into shadow0, go to EXP1. Any other strobe: stay in SEARCH, no error.
- EXP1: strobe with gap==GAP1 → capture into shadow1, go to EXP2.
- EXP2: strobe with gap==GAP2 → on the same edge:
  - o_slot0 ← shadow0, o_slot1 ← shadow1, o_slot2 ← i_data
  - o_frame_valid ← 1, o_locked ← 1
  - go to EXP0
- EXP0: strobe with gap==GAP0 → capture into shadow0, go to EXP1.
- Mismatch: in EXP0/1/2, a strobe with the wrong gap → o_err=1, o_locked=0, go to SEARCH.
  - The offending strobe is not re-evaluated in SEARCH.
  - gap_cnt still clears on it.
- Timeout: in EXP0/1/2, no strobe and gap_cnt==TIMEOUT-1 → o_err=1, o_locked=0, go to SEARCH.
- o_slot* hold their values through errors and SEARCH; they change only on a completed frame.
- Shadow registers are never visible on outputs.

## Timing
- All outputs are registered.
- Strobe at edge n: state, shadow and o_slot* updates are visible after edge n.
- o_frame_valid and o_err are high for exactly the one cycle following the strobe/timeout edge.
- Latency: slot-2 strobe at frame cycle 24 → o_frame_valid high during cycle 25.
- Simultaneous strobe and timeout condition: the strobe wins and its gap is evaluated. A gap of TIMEOUT never matches, so o_err asserts once, not twice.
- Reset values: state=SEARCH, gap_cnt=0, seen=0, shadows=0, o_slot*=0, o_frame_valid=0, o_locked=0, o_err=0.
- Reset mid-frame discards the partial frame; re-lock requires a full new GAP0/GAP1/GAP2 sequence.
- Lock acquisition from reset in a steady stream takes three strobes after the first: gaps 12, 16, 4.
- Back-to-back strobes (gap 1) are legal input and evaluate as gap=1.

## Configuration
- Macro CTRL_FRAME_STATS_EN.
- Defined: adds output o_err_count, out, 8 bits.
  - Increments on every o_err assertion, on the same edge that sets o_err.
  - Saturates at 255.
  - Reset to 0.
  - Unaffected by lock state.
- Undefined: port and counter are absent; all other behaviour is identical.

## Test plan
- Steady stream: drive strobes at cycles 4, 20, 24 mod 32 with i_data = 0x11/0x22/0x33 on each frame's strobes.
  - o_locked rises after the first complete 12/16/4 sequence.
  - o_frame_valid pulses each frame at cycle 25.
  - o_slot0/1/2 = 0x11/0x22/0x33.
- Gap mismatch: while locked, move the slot-1 strobe from cycle 20 to 19 (gap 15).
  - o_err pulses once, o_locked=0, o_slot* retain the previous frame.
  - Re-lock occurs after the next full 12/16/4 sequence.
- Timeout: while locked, stop strobes after cycle 20.
  - o_err pulses 64 cycles after the cycle-20 strobe, o_locked=0.
  - No further errors follow while strobes stay absent.
- Reset mid-frame: assert reset asynchronously between the slot-0 and slot-1 strobes.
  - All outputs read 0 immediately.
  - The first post-reset frame produces no o_frame_valid; the subsequent full sequence does.
- Spurious extra strobe: while locked, add a strobe at cycle 10.
  - o_err pulses.
  - The strobes at 20/24 do not produce o_frame_valid.
  - Lock returns after the next 4 (gap 12) → 20 → 24 sequence.
- With CTRL_FRAME_STATS_EN: force 300 mismatches → o_err_count saturates at 255; reset → 0.
